mult_div_unit: RTL and testbench

- Iterative multiply/divide unit with HI/LO registers for the single-clock MIPS core.
- Sits beside the EX stage:
  - It consumes operands and an op code issued from ID/EX.
  - It produces HI/LO values that are read back through the MFHI/MFLO datapath.
- Busy is the stall request to the hazard unit; Done marks the writeback of a multi-cycle result.

---
 rtl/mult_div_unit.sv | 134 +++++++++++++
 tb/tb_mult_div_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// Performs one shift-add or restoring-subtract step per cycle, then applies signs in a fix-up cycle.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              busy_q, done_q;
    logic              is_div_q, neg_q, rem_neg_q, dbz_q;
    logic [WIDTH-1:0]  opa_q, acc_q, lo_acc_q;
    logic [WIDTH-1:0]  hi_q, lo_q;

    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]  acc_d, lo_acc_d;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]  quo_fix, rem_fix, fix_hi, fix_lo;

    always_comb begin
        // op_i[0] clear selects the signed variants (MULT/DIV)
        a_neg = ~op_i[0] & a_i[WIDTH-1];
        b_neg = ~op_i[0] & b_i[WIDTH-1];
        a_mag = a_neg ? (~a_i + WIDTH'(1)) : a_i;
        b_mag = b_neg ? (~b_i + WIDTH'(1)) : b_i;

        mul_sum   = {1'b0, acc_q} + (lo_acc_q[0] ? {1'b0, opa_q} : '0);
        div_shift = {acc_q, lo_acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opa_q};

        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                acc_d    = div_diff[WIDTH-1:0];
                lo_acc_d = {lo_acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d    = div_shift[WIDTH-1:0];
                lo_acc_d = {lo_acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d    = mul_sum[WIDTH:1];
            lo_acc_d = {mul_sum[0], lo_acc_q[WIDTH-1:1]};
        end

        prod     = {acc_q, lo_acc_q};
        prod_fix = neg_q ? (~prod + (2*WIDTH)'(1)) : prod;
        // Divide by zero must yield all ones regardless of operand signs
        quo_fix  = dbz_q ? '1 : (neg_q ? (~lo_acc_q + WIDTH'(1)) : lo_acc_q);
        rem_fix  = rem_neg_q ? (~acc_q + WIDTH'(1)) : acc_q;
        fix_hi   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
            opa_q     <= '0;
            acc_q     <= '0;
            lo_acc_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        case (op_i)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                state_q   <= StRun;
                                busy_q    <= 1'b1;
                                cnt_q     <= CntW'(WIDTH - 1);
                                is_div_q  <= op_i[1];
                                neg_q     <= a_neg ^ b_neg;
                                rem_neg_q <= a_neg;
                                dbz_q     <= (b_i == '0);
                                acc_q     <= '0;
                                opa_q     <= op_i[1] ? b_mag : a_mag;
                                lo_acc_q  <= op_i[1] ? a_mag : b_mag;
                            end
                            3'b100:  hi_q <= a_i;
                            3'b101:  lo_q <= a_i;
                            default: ;
                        endcase
                    end
                end
                StRun: begin
                    acc_q    <= acc_d;
                    lo_acc_q <= lo_acc_d;
                    if (cnt_q == '0) begin
                        state_q <= StFix;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StFix: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table for the arithmetic plus handshake/reset sequences.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b111;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op = 3'b111;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_done(input int already, input string name,
                             input logic [31:0] eh, input logic [31:0] el);
        int n = already;
        while (busy && n < 100) begin
            if (n == 10) begin
                chk({name, "/hold_hi"}, hi, m_hi);
                chk({name, "/hold_lo"}, lo, m_lo);
            end
            n++;
            @(negedge clk);
        end
        chk({name, "/busy_len"}, n, 33);
        chk({name, "/done"}, {31'b0, done}, 32'd1);
        chk({name, "/hi"}, hi, eh);
        chk({name, "/lo"}, lo, el);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
        vecs[1]  = '{3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_m3x7"};
        vecs[2]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min2"};
        vecs[3]  = '{3'b000, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, "mult_neg1"};
        vecs[4]  = '{3'b001, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, "multu_2p32"};
        vecs[5]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7d2"};
        vecs[6]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7dm2"};
        vecs[7]  = '{3'b010, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, "div_m7dm2"};
        vecs[8]  = '{3'b011, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100d7"};
        vecs[9]  = '{3'b011, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, "divu_max16"};
        vecs[10] = '{3'b011, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, "divu_by0"};
        vecs[11] = '{3'b010, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_neg_by0"};
        vecs[12] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
        vecs[13] = '{3'b001, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 32'h00000000, "multu_zero"};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst/hi", hi, 32'h0);
        chk("rst/lo", lo, 32'h0);
        chk("rst/busy", {31'b0, busy}, 32'd0);
        chk("rst/done", {31'b0, done}, 32'd0);

        // Reset in the middle of a MULTU aborts without touching HI/LO
        start_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) @(negedge clk);
        chk("abort/busy_before", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort/busy", {31'b0, busy}, 32'd0);
        chk("abort/hi", hi, 32'h0);
        chk("abort/lo", lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_hi = '0;
        m_lo = '0;

        for (int i = 0; i < 14; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(0, vecs[i].name, vecs[i].hi, vecs[i].lo);
            @(negedge clk);
            chk({vecs[i].name, "/done_width"}, {31'b0, done}, 32'd0);
        end

        // MTLO / MTHI take effect at the accepting edge with no busy/done
        start = 1'b1; op = 3'b101; a = 32'h00001234;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        m_lo = 32'h00001234;
        chk("mtlo/lo", lo, m_lo);
        chk("mtlo/hi", hi, m_hi);
        chk("mtlo/busy", {31'b0, busy}, 32'd0);
        chk("mtlo/done", {31'b0, done}, 32'd0);

        start = 1'b1; op = 3'b100; a = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        m_hi = 32'hCAFEF00D;
        chk("mthi/hi", hi, m_hi);
        chk("mthi/busy", {31'b0, busy}, 32'd0);

        // NOP op codes do nothing
        start = 1'b1; op = 3'b110; a = 32'h55555555; b = 32'h3;
        @(posedge clk);
        @(negedge clk);
        op = 3'b111;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("nop/hi", hi, m_hi);
        chk("nop/lo", lo, m_lo);
        chk("nop/busy", {31'b0, busy}, 32'd0);

        // MTHI issued mid-divide is ignored
        start_op(3'b011, 32'd100, 32'd7);
        start = 1'b1; op = 3'b100; a = 32'h0000DEAD;
        @(negedge clk);
        start = 1'b0; op = 3'b111;
        wait_done(1, "divu_mthi", 32'd2, 32'd14);
        @(negedge clk);

        // Start in the Done cycle is accepted
        start_op(3'b001, 32'd3, 32'd5);
        wait_done(0, "b2b_first", 32'd0, 32'd15);
        start_op(3'b001, 32'd6, 32'd7);
        chk("b2b/busy_rise", {31'b0, busy}, 32'd1);
        chk("b2b/done_low", {31'b0, done}, 32'd0);
        wait_done(0, "b2b_second", 32'd0, 32'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
